// File: rtl/lcd_pkg.sv
// Shared LCD panel constants, framebuffer types and arbiter state encoding.
package lcd_pkg;

  // 480x272 panel timing (pixel clocks / lines)
  localparam int unsigned H_Pixel_Valid = 480;
  localparam int unsigned H_Front_Porch = 2;
  localparam int unsigned H_Sync_Width  = 41;
  localparam int unsigned H_Back_Porch  = 2;
  localparam int unsigned V_Pixel_Valid = 272;
  localparam int unsigned V_Front_Porch = 2;
  localparam int unsigned V_Sync_Width  = 10;
  localparam int unsigned V_Back_Porch  = 2;
  localparam int unsigned PixelForHS    = H_Pixel_Valid + H_Front_Porch + H_Sync_Width + H_Back_Porch;
  localparam int unsigned PixelForVS    = V_Pixel_Valid + V_Front_Porch + V_Sync_Width + V_Back_Porch;

  localparam int unsigned FB_WORDS  = H_Pixel_Valid * V_Pixel_Valid;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned PIX_W     = 16;
  localparam int unsigned DROP_W    = 16;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  // RGB565 pixel word
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  // Linear framebuffer word address of pixel (x, y)
  function automatic fb_addr_t fb_addr_of(input int unsigned x, input int unsigned y);
    return FB_ADDR_W'(y * H_Pixel_Valid + x);
  endfunction

endpackage

// File: rtl/lcd_fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its environment
// (timing generator, host writer, framebuffer RAM).
// slave = arbiter side, master = environment side.
interface lcd_fb_arbiter_if
  import lcd_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = PIX_W,
  parameter int unsigned CNT_W  = DROP_W
);

  // display line requests and scan-out
  logic              line_req;
  logic [ADDR_W-1:0] line_base;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              disp_last;
  logic              busy;
  logic              line_drop;

  // host write path
  logic              host_valid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;

  // framebuffer RAM port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [CNT_W-1:0]  drop_count;

  modport slave (
    input  line_req, line_base, host_valid, host_addr, host_data, mem_rdata,
    output disp_data, disp_valid, disp_last, busy, line_drop, host_ready,
           mem_en, mem_we, mem_addr, mem_wdata, drop_count
  );

  modport master (
    output line_req, line_base, host_valid, host_addr, host_data, mem_rdata,
    input  disp_data, disp_valid, disp_last, busy, line_drop, host_ready,
           mem_en, mem_we, mem_addr, mem_wdata, drop_count
  );

endinterface

// File: rtl/lcd_fb_arbiter.sv
// Framebuffer RAM arbiter: display line bursts have strict priority,
// host single-word writes fill the gaps (blanking).
// Optional macro LCD_FB_ARB_DROP_CNT_EN builds a saturating counter of
// dropped line requests; otherwise drop_count is tied to 0.
module lcd_fb_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned ADDR_W    = FB_ADDR_W,
  parameter int unsigned DATA_W    = PIX_W,
  parameter int unsigned BURST_LEN = H_Pixel_Valid,
  parameter int unsigned CNT_W     = DROP_W
) (
  input logic             PixelClk,
  input logic             RST,
  lcd_fb_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BURST_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'(ARB_IDLE);
  localparam logic [1:0] S_BURST = 2'(ARB_BURST);
  localparam logic [1:0] S_DRAIN = 2'(ARB_DRAIN);

  logic [1:0]        r_state,     w_state;
  logic [IDX_W-1:0]  r_idx,       w_idx;
  logic [ADDR_W-1:0] r_base,      w_base;
  logic              r_mem_en,    w_mem_en;
  logic              r_mem_we,    w_mem_we;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
  logic              r_mem_last,  w_mem_last;   // last burst read on the RAM port
  logic              r_rd_pend,   w_rd_pend;    // RAM read data arrives this cycle
  logic              r_rd_last,   w_rd_last;    // ... and it is the final word
  logic [DATA_W-1:0] r_disp_data, w_disp_data;
  logic              r_disp_valid, w_disp_valid;
  logic              r_disp_last, w_disp_last;
  logic              r_busy,      w_busy;
  logic              r_line_drop, w_line_drop;

  // Next-state and registered-output logic
  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_base       = r_base;
    w_mem_en     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_mem_last   = 1'b0;
    w_rd_pend    = r_mem_en && !r_mem_we;
    w_rd_last    = r_mem_last;
    w_disp_valid = r_rd_pend;
    w_disp_data  = r_rd_pend ? bus.mem_rdata : r_disp_data;
    w_disp_last  = r_rd_last;
    w_line_drop  = bus.line_req && (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (bus.line_req) begin
          w_mem_en   = 1'b1;
          w_mem_addr = bus.line_base;
          w_base     = bus.line_base;
          w_idx      = IDX_W'(1);
          if (BURST_LEN == 1) begin
            w_mem_last = 1'b1;
            w_state    = S_DRAIN;
          end else begin
            w_state    = S_BURST;
          end
        end else if (bus.host_valid) begin
          w_mem_en    = 1'b1;
          w_mem_we    = 1'b1;
          w_mem_addr  = bus.host_addr;
          w_mem_wdata = bus.host_data;
        end
      end
      S_BURST: begin
        // address wraps modulo 2^ADDR_W by truncation
        w_mem_en   = 1'b1;
        w_mem_addr = ADDR_W'(r_base + ADDR_W'(r_idx));
        w_idx      = IDX_W'(r_idx + IDX_W'(1));
        if (r_idx == IDX_W'(BURST_LEN - 1)) begin
          w_mem_last = 1'b1;
          w_state    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // leave on the edge that presents the final word
        if (r_rd_last) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    // covers the cycle carrying disp_last as well
    w_busy = (r_state != S_IDLE) || (w_state != S_IDLE);
  end

  // State and output registers; reset abandons any burst in flight
  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_base       <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_last   <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_last    <= 1'b0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
      r_disp_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_line_drop  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_base       <= w_base;
      r_mem_en     <= w_mem_en;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_mem_last   <= w_mem_last;
      r_rd_pend    <= w_rd_pend;
      r_rd_last    <= w_rd_last;
      r_disp_data  <= w_disp_data;
      r_disp_valid <= w_disp_valid;
      r_disp_last  <= w_disp_last;
      r_busy       <= w_busy;
      r_line_drop  <= w_line_drop;
    end
  end

`ifdef LCD_FB_ARB_DROP_CNT_EN
  logic [CNT_W-1:0] r_drop_cnt;

  // Saturating count of dropped line requests, cleared only by reset
  always_ff @(posedge PixelClk or posedge RST) begin
    if (RST) begin
      r_drop_cnt <= '0;
    end else if (w_line_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign bus.drop_count = r_drop_cnt;
`else
  assign bus.drop_count = CNT_W'(0);
`endif

  // host may only write while idle and not losing to a display request
  assign bus.host_ready = !RST && (r_state == S_IDLE) && !bus.line_req;

  assign bus.disp_data  = r_disp_data;
  assign bus.disp_valid = r_disp_valid;
  assign bus.disp_last  = r_disp_last;
  assign bus.busy       = r_busy;
  assign bus.line_drop  = r_line_drop;
  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Self-checking bench for lcd_fb_arbiter with BURST_LEN=4 and a behavioural
// single-port RAM. Expected traces come from a word-level model of the
// framebuffer (ref_mem) plus the cycle rules of a display burst.
// Build with +define+LCD_FB_ARB_DROP_CNT_EN to also exercise the drop counter.
module tb_lcd_fb_arbiter;

  localparam int unsigned AW        = 17;
  localparam int unsigned DW        = 16;
  localparam int unsigned CW        = 16;
  localparam int unsigned BL        = 4;
  localparam int unsigned RAM_WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus();

  lcd_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW)) u_dut (
    .PixelClk (clk),
    .RST      (rst),
    .bus      (bus)
  );

  // Behavioural framebuffer RAM, preloaded with address-as-data
  logic [DW-1:0] ram [RAM_WORDS];
  logic [DW-1:0] ram_q = '0;
  bit            ram_ready = 1'b0;
  assign bus.mem_rdata = ram_q;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= DW'(i);
      ram_ready <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr];
    end
  end

  // Expected framebuffer contents
  logic [DW-1:0] ref_mem [RAM_WORDS];
  int n_cmp = 0;
  int n_err = 0;
  int model_drops = 0;

  function automatic logic [CW-1:0] exp_dc();
`ifdef LCD_FB_ARB_DROP_CNT_EN
    return CW'(model_drops);
`else
    return CW'(0);
`endif
  endfunction

  function automatic logic [71:0] pack_all();
    return {bus.disp_data, bus.disp_valid, bus.disp_last, bus.busy, bus.line_drop,
            bus.host_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
            bus.drop_count};
  endfunction

  // One display burst from 'base'; optionally a host write held from the
  // start and a second line_req injected at cycle drop_at (-1 = none).
  // Cycle c is the cycle following edge Ec, E0 being the accepting edge.
  task automatic run_burst(input logic [AW-1:0] base, input bit hold_host,
                           input logic [AW-1:0] h_addr, input logic [DW-1:0] h_data,
                           input int drop_at, input string name);
    logic [AW-1:0] a;
    logic [71:0]   obs, exp;
    bit            e_en, e_we, e_dv, e_dl, e_busy, e_hr, e_drop;
    logic [AW-1:0] e_addr, m_addr;
    logic [DW-1:0] e_wd, m_wd, e_dd, m_dd;
    bus.line_req   = 1'b1;
    bus.line_base  = base;
    bus.host_valid = hold_host;
    bus.host_addr  = h_addr;
    bus.host_data  = h_data;
    #1;
    n_cmp++;
    if (bus.host_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s start host_ready: got %b want 0", name, bus.host_ready);
    end
    for (int c = 0; c <= int'(BL) + 2; c++) begin
      @(negedge clk);
      bus.line_req = (c == drop_at);
      if (c == drop_at) bus.line_base = AW'($urandom);
      bus.host_valid = hold_host && (c < int'(BL) + 2);
      #1;
      if (drop_at >= 0 && c == drop_at + 1 && model_drops < 65535) model_drops++;
      a      = base + AW'(c);
      e_we   = hold_host && (c == int'(BL) + 2);
      e_en   = (c < int'(BL)) || e_we;
      e_addr = (c < int'(BL)) ? a : (e_we ? h_addr : '0);
      m_addr = e_en ? bus.mem_addr : '0;
      e_wd   = e_we ? h_data : '0;
      m_wd   = e_we ? bus.mem_wdata : '0;
      e_dv   = (c >= 2) && (c <= int'(BL) + 1);
      e_dd   = e_dv ? ref_mem[AW'(base + AW'(c - 2))] : '0;
      m_dd   = e_dv ? bus.disp_data : '0;
      e_dl   = (c == int'(BL) + 1);
      e_busy = (c <= int'(BL) + 1);
      e_hr   = (c >= int'(BL) + 1);
      e_drop = (drop_at >= 0) && (c == drop_at + 1);
      obs = {bus.mem_en, bus.mem_we, m_addr, m_wd, bus.disp_valid, m_dd, bus.disp_last,
             bus.busy, bus.host_ready, bus.line_drop, bus.drop_count};
      exp = {e_en, e_we, e_addr, e_wd, e_dv, e_dd, e_dl, e_busy, e_hr, e_drop, exp_dc()};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s c=%0d {en,we,addr,wd,dv,dd,dl,busy,hr,drop,dc}: got %h want %h",
                 name, c, obs, exp);
      end
    end
    if (hold_host) ref_mem[h_addr] = h_data;
    bus.host_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.line_req = 1'b0; bus.line_base = '0;
    bus.host_valid = 1'b1; bus.host_addr = '0; bus.host_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (pack_all() !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got %h want 0", pack_all());
    end
    bus.host_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_drops = 0;
    #1;
    n_cmp++;
    if (bus.host_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset idle host_ready: got %b want 1", bus.host_ready);
    end
  endtask

  task automatic test_host_write();
    bus.host_valid = 1'b1; bus.host_addr = 17'h00010; bus.host_data = 16'hF800;
    #1;
    n_cmp++;
    if (bus.host_ready !== 1'b1) begin
      n_err++;
      $display("FAIL host_write ready: got %b want 1", bus.host_ready);
    end
    @(negedge clk);
    bus.host_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 17'h00010, 16'hF800}) begin
      n_err++;
      $display("FAIL host_write port: got %b %b %h %h want 1 1 00010 f800",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    ref_mem[17'h00010] = 16'hF800;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL host_write idle mem_en: got %b want 0", bus.mem_en);
    end
    run_burst(17'h00010, 1'b0, '0, '0, -1, "host_readback");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] base, pa;
    logic [DW-1:0] pd;
    base = AW'($urandom);
    pa = '0; pd = '0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin
        n_cmp++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, pa, pd}) begin
          n_err++;
          $display("FAIL b2b write %0d: got %b %b %h %h want 1 1 %h %h", k,
                   bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, pa, pd);
        end
      end
      if (k < 6) begin
        pa = base + AW'($urandom_range(0, BL - 1));
        pd = DW'($urandom);
        bus.host_valid = 1'b1; bus.host_addr = pa; bus.host_data = pd;
        ref_mem[pa] = pd;
        #1;
        n_cmp++;
        if (bus.host_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b ready %0d: got %b want 1", k, bus.host_ready);
        end
        @(negedge clk);
        #1;
      end
    end
    bus.host_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL b2b idle mem_en: got %b want 0", bus.mem_en);
    end
    run_burst(base, 1'b0, '0, '0, -1, "b2b_readback");
  endtask

  task automatic test_collision();
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    ha = AW'($urandom);
    hd = DW'($urandom);
    run_burst(AW'($urandom), 1'b1, ha, hd, -1, "collision");
    run_burst(ha - AW'(1), 1'b0, '0, '0, -1, "collision_readback");
  endtask

  task automatic test_random_bursts();
    for (int i = 0; i < 8; i++)
      run_burst(AW'($urandom), 1'b0, '0, '0, int'($urandom_range(0, BL + 1)) - 1, "random_burst");
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] base;
    base = AW'($urandom);
    bus.line_req = 1'b1; bus.line_base = base;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      bus.line_req = 1'b0;
      #1;
    end
    n_cmp++;
    if ({bus.disp_valid, bus.disp_data} !== {1'b1, ref_mem[AW'(base + AW'(1))]}) begin
      n_err++;
      $display("FAIL reset_mid 2nd word: got %b %h want 1 %h", bus.disp_valid, bus.disp_data,
               ref_mem[AW'(base + AW'(1))]);
    end
    rst = 1'b1;
    model_drops = 0;
    #1;
    n_cmp++;
    if (pack_all() !== '0) begin
      n_err++;
      $display("FAIL reset_mid outputs: got %h want 0", pack_all());
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({bus.disp_last, bus.disp_valid, bus.busy, bus.mem_en} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_mid held %0d {dl,dv,busy,en}: got %b want 0000", k,
                 {bus.disp_last, bus.disp_valid, bus.busy, bus.mem_en});
      end
    end
    rst = 1'b0;
    #1;
    run_burst(base + AW'(7), 1'b0, '0, '0, -1, "post_reset_burst");
  endtask

`ifdef LCD_FB_ARB_DROP_CNT_EN
  task automatic test_drop_saturate();
    // line_req held: 5 of every 6 edges fall in a busy window
    bus.line_req = 1'b1;
    bus.line_base = AW'($urandom);
    repeat (79000) @(negedge clk);
    bus.line_req = 1'b0;
    repeat (BL + 4) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.drop_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL drop_saturate: got %h want ffff", bus.drop_count);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = DW'(i);
    bus.line_req = 1'b0; bus.line_base = '0;
    bus.host_valid = 1'b0; bus.host_addr = '0; bus.host_data = '0;
    test_reset();
    run_burst(17'h00100, 1'b0, '0, '0, -1, "basic_burst");
    test_host_write();
    test_collision();
    run_burst(17'h00200, 1'b0, '0, '0, 2, "drop_in_burst");
    run_burst(17'h1FFFE, 1'b0, '0, '0, -1, "wrap_burst");
    run_burst(17'h00300, 1'b0, '0, '0, int'(BL), "drop_in_drain");
    test_back_to_back();
    test_random_bursts();
    test_reset_mid();
`ifdef LCD_FB_ARB_DROP_CNT_EN
    test_drop_saturate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
